prog_counter_ext: RTL and testbench
===================================

PROG_COUNTER_EXT -- requirements
Module: prog_counter_ext

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, counter width in bits (legal range 8..32).
REQ-002 The block SHALL have parameter RESET_VAL, default 0, value PC_COUNT takes on reset, truncated to WIDTH.
REQ-003 The block SHALL have port PC_CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port PC_RST  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port PC_LD  input  1  absolute load of PC_DIN.
REQ-006 The block SHALL have port PC_DIN  input  WIDTH  absolute load value.
REQ-007 The block SHALL have port PC_VEC  input  1  vector load (RST n or interrupt).
REQ-008 The block SHALL have port PC_VSEL  input  4  vector select.
REQ-009 The block SHALL have port PC_REL  input  1  relative jump.
REQ-010 The block SHALL have port PC_OFS  input  8  signed two's-complement relative offset.
REQ-011 The block SHALL have port PC_INC  input  1  increment by one.
REQ-012 The block SHALL have port PC_HBUG  input  1  arm halt-bug increment suppression.
REQ-013 The block SHALL have port PC_COUNT  output  WIDTH  current program counter, registered.
REQ-014 The block SHALL have port PC_PREV  output  WIDTH  PC_COUNT value before its most recent change, registered.
REQ-015 The block SHALL have port PC_WRAP  output  1  one-cycle pulse after an increment from all-ones to zero.
REQ-016 The block SHALL have port PC_VERR  output  1  one-cycle pulse after a vector request with an illegal PC_VSEL.

Function
REQ-017 Per edge, at most one operation SHALL take effect, priority PC_RST > PC_LD > PC_VEC > PC_REL > PC_INC > hold.
REQ-018 PC_LD SHALL set PC_COUNT to PC_DIN on the next edge (latency 1).
REQ-019 PC_VEC with PC_VSEL 0..7 SHALL load 8*PC_VSEL (RST vectors 0x00..0x38), zero-extended to WIDTH.
REQ-020 PC_VEC with PC_VSEL 8..12 SHALL load 0x40 + 8*(PC_VSEL-8) (interrupt vectors 0x40..0x60).
REQ-021 PC_VEC with PC_VSEL 13..15 SHALL leave PC_COUNT and PC_PREV unchanged, SHALL pulse PC_VERR for one cycle, and SHALL NOT fall through to PC_REL or PC_INC that cycle.
REQ-022 PC_REL SHALL set PC_COUNT to PC_COUNT + sign-extended PC_OFS, modulo 2^WIDTH; an offset of 0 SHALL still count as a change for PC_PREV.
REQ-023 PC_INC SHALL set PC_COUNT to PC_COUNT + 1, modulo 2^WIDTH.
REQ-024 PC_WRAP SHALL assert for exactly one cycle following an executed increment from 2^WIDTH-1 to 0, and SHALL NOT assert on PC_REL or load wrap.
REQ-025 PC_PREV SHALL capture the pre-edge PC_COUNT on every executed LD, legal VEC, REL or executed INC, and SHALL hold otherwise.
REQ-026 All outputs SHALL be driven from registers only, with no combinational input-to-output path.

Reset
REQ-027 On a PC_RST edge: PC_COUNT = RESET_VAL, PC_PREV = RESET_VAL, PC_WRAP = 0, PC_VERR = 0, halt-bug flag cleared.
REQ-028 PC_RST SHALL override every other input on the same edge, including mid-sequence halt-bug arming.

Configuration
REQ-029 Macro PC_HALT_BUG_EN SHALL, when defined, compile in a sticky halt-bug flag, set by PC_HBUG on an edge.
REQ-030 With PC_HALT_BUG_EN defined, the first PC_INC executed while the flag is set SHALL leave PC_COUNT, PC_PREV and PC_WRAP unchanged and SHALL clear the flag.
REQ-031 With PC_HALT_BUG_EN defined, a PC_HBUG arriving on the same edge as an executed PC_INC SHALL let that increment proceed and SHALL arm the flag for the next one.
REQ-032 With PC_HALT_BUG_EN defined, PC_LD, PC_VEC or PC_REL SHALL clear the flag without consuming a suppression.
REQ-033 Without PC_HALT_BUG_EN, PC_HBUG SHALL be ignored and no flag register SHALL be synthesised.

Verification
REQ-034 The bench SHALL cover reset with RESET_VAL=0x0100, then 3 PC_INC cycles -> PC_COUNT=0x0103, PC_PREV=0x0102.
REQ-035 The bench SHALL cover PC_COUNT=0x0150 with PC_REL and PC_OFS=0xFE -> 0x014E; then PC_OFS=0x7F -> 0x01CD.
REQ-036 The bench SHALL cover PC_VEC with PC_VSEL=7 -> 0x0038; PC_VSEL=10 -> 0x0050; PC_VSEL=14 -> PC_COUNT held and PC_VERR pulsed one cycle.
REQ-037 The bench SHALL cover PC_COUNT=0xFFFF with PC_INC -> 0x0000 and PC_WRAP high one cycle; PC_LD+PC_INC with PC_DIN=0x1234 -> 0x1234.
REQ-038 With PC_HALT_BUG_EN, the bench SHALL cover PC_COUNT=0x0200, PC_HBUG pulse then PC_INC x2 -> 0x0200 after first, 0x0201 after second.
REQ-039 The bench SHALL cover PC_RST asserted together with PC_LD, PC_VEC and PC_INC -> PC_COUNT=RESET_VAL, PC_WRAP=0, PC_VERR=0.

Source files
------------

// File: rtl/prog_counter_ext.sv
// Program counter with absolute load, vector load, signed relative jump and increment.
// Define PC_HALT_BUG_EN to add a sticky flag that swallows the next increment after PC_HBUG.
module prog_counter_ext #(
    parameter int          WIDTH     = 16,
    parameter logic [31:0] RESET_VAL = 32'd0
) (
    input  logic             PC_CLK,
    input  logic             PC_RST,
    input  logic             PC_LD,
    input  logic [WIDTH-1:0] PC_DIN,
    input  logic             PC_VEC,
    input  logic [3:0]       PC_VSEL,
    input  logic             PC_REL,
    input  logic [7:0]       PC_OFS,
    input  logic             PC_INC,
    input  logic             PC_HBUG,
    output logic [WIDTH-1:0] PC_COUNT,
    output logic [WIDTH-1:0] PC_PREV,
    output logic             PC_WRAP,
    output logic             PC_VERR
);

    localparam logic [WIDTH-1:0] RST_V = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_prev;
    logic             r_wrap;
    logic             r_verr;

    logic [WIDTH-1:0] w_nxt_count;
    logic [WIDTH-1:0] w_nxt_prev;
    logic             w_nxt_wrap;
    logic             w_nxt_verr;
    logic             w_clr_flag;
    logic             w_suppress;
    logic             w_vsel_ok;
    logic [WIDTH-1:0] w_vec_val;
    logic [WIDTH-1:0] w_ofs_ext;

    // RST and interrupt vectors are contiguous: both reduce to 8*VSEL for VSEL 0..12
    assign w_vsel_ok = (PC_VSEL <= 4'd12);
    assign w_vec_val = WIDTH'({PC_VSEL, 3'b000});
    assign w_ofs_ext = WIDTH'($signed(PC_OFS));

`ifdef PC_HALT_BUG_EN
    logic r_hbug;
    assign w_suppress = r_hbug;

    always_ff @(posedge PC_CLK) begin
        if (PC_RST) begin
            r_hbug <= 1'b0;
        end else begin
            r_hbug <= PC_HBUG | (r_hbug & ~w_clr_flag);
        end
    end
`else
    logic w_unused_hbug;
    assign w_unused_hbug = PC_HBUG;
    assign w_suppress    = 1'b0;
`endif

    always_comb begin
        w_nxt_count = r_count;
        w_nxt_prev  = r_prev;
        w_nxt_wrap  = 1'b0;
        w_nxt_verr  = 1'b0;
        w_clr_flag  = 1'b0;
        if (PC_LD) begin
            w_nxt_count = PC_DIN;
            w_nxt_prev  = r_count;
            w_clr_flag  = 1'b1;
        end else if (PC_VEC) begin
            w_clr_flag = 1'b1;
            if (w_vsel_ok) begin
                w_nxt_count = w_vec_val;
                w_nxt_prev  = r_count;
            end else begin
                w_nxt_verr = 1'b1;
            end
        end else if (PC_REL) begin
            w_nxt_count = r_count + w_ofs_ext;
            w_nxt_prev  = r_count;
            w_clr_flag  = 1'b1;
        end else if (PC_INC) begin
            // a suppressed increment consumes the armed flag and changes nothing else
            w_clr_flag = 1'b1;
            if (!w_suppress) begin
                w_nxt_count = r_count + WIDTH'(1);
                w_nxt_prev  = r_count;
                w_nxt_wrap  = &r_count;
            end
        end
    end

    always_ff @(posedge PC_CLK) begin
        if (PC_RST) begin
            r_count <= RST_V;
            r_prev  <= RST_V;
            r_wrap  <= 1'b0;
            r_verr  <= 1'b0;
        end else begin
            r_count <= w_nxt_count;
            r_prev  <= w_nxt_prev;
            r_wrap  <= w_nxt_wrap;
            r_verr  <= w_nxt_verr;
        end
    end

    assign PC_COUNT = r_count;
    assign PC_PREV  = r_prev;
    assign PC_WRAP  = r_wrap;
    assign PC_VERR  = r_verr;

endmodule

// File: tb/tb_prog_counter_ext.sv
// Directed bench for prog_counter_ext: per-cycle compare against an arithmetic model plus literal pins.
module tb_prog_counter_ext;

    localparam int          W  = 16;
    localparam logic [31:0] RV = 32'h0100;

    logic         clk = 1'b0;
    logic         rst = 1'b0, ld = 1'b0, vec = 1'b0, rel = 1'b0, inc = 1'b0, hbug = 1'b0;
    logic [W-1:0] din = '0;
    logic [3:0]   vsel = '0;
    logic [7:0]   ofs = '0;
    logic [W-1:0] count, prev;
    logic         wrap, verr;

    int n_tests = 0;
    int n_fail  = 0;

    prog_counter_ext #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .PC_CLK(clk), .PC_RST(rst), .PC_LD(ld), .PC_DIN(din), .PC_VEC(vec),
        .PC_VSEL(vsel), .PC_REL(rel), .PC_OFS(ofs), .PC_INC(inc), .PC_HBUG(hbug),
        .PC_COUNT(count), .PC_PREV(prev), .PC_WRAP(wrap), .PC_VERR(verr)
    );

    always #5 clk = ~clk;

    // model state, advanced from the inputs seen at each rising edge
    int  m_count, m_prev;
    bit  m_wrap, m_verr, m_flag, m_valid = 0;
    bit  hb_en;

    initial begin
        hb_en = 0;
`ifdef PC_HALT_BUG_EN
        hb_en = 1;
`endif
    end

    always @(posedge clk) begin
        int nxt;
        m_wrap = 0;
        m_verr = 0;
        if (rst) begin
            m_count = RV; m_prev = RV; m_flag = 0; m_valid = 1;
        end else if (ld) begin
            m_prev = m_count; m_count = din; m_flag = hbug;
        end else if (vec) begin
            if (vsel < 8) begin
                m_prev = m_count; m_count = 8 * vsel;
            end else if (vsel < 13) begin
                m_prev = m_count; m_count = 'h40 + 8 * (vsel - 8);
            end else m_verr = 1;
            m_flag = hbug;
        end else if (rel) begin
            nxt = m_count + $signed(ofs);
            m_prev = m_count; m_count = ((nxt % 65536) + 65536) % 65536;
            m_flag = hbug;
        end else if (inc) begin
            if (hb_en && m_flag) m_flag = hbug;
            else begin
                nxt = (m_count + 1) % 65536;
                m_wrap = (nxt == 0);
                m_prev = m_count; m_count = nxt;
                m_flag = hb_en && hbug;
            end
        end else begin
            m_flag = hb_en && (m_flag || hbug);
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_count", count, W'(m_count));
            check("model_prev",  prev,  W'(m_prev));
            check("model_wrap",  W'(wrap), W'(m_wrap));
            check("model_verr",  W'(verr), W'(m_verr));
        end
    end

    // drive at the falling edge, return at the next falling edge with outputs settled
    task automatic cyc(input logic r, input logic l, input logic [W-1:0] d, input logic v,
                       input logic [3:0] vs, input logic re, input logic [7:0] o,
                       input logic i, input logic h);
        rst = r; ld = l; din = d; vec = v; vsel = vs; rel = re; ofs = o; inc = i; hbug = h;
        @(negedge clk);
        rst = 0; ld = 0; vec = 0; rel = 0; inc = 0; hbug = 0;
    endtask

    task automatic do_inc();            cyc(0,0,'0,0,4'd0,0,8'd0,1,0); endtask
    task automatic do_ld(input logic [W-1:0] d); cyc(0,1,d,0,4'd0,0,8'd0,0,0); endtask
    task automatic do_rel(input logic [7:0] o);  cyc(0,0,'0,0,4'd0,1,o,0,0); endtask
    task automatic do_vec(input logic [3:0] s);  cyc(0,0,'0,1,s,0,8'd0,0,0); endtask
    task automatic do_idle();           cyc(0,0,'0,0,4'd0,0,8'd0,0,0); endtask

    initial begin
        @(negedge clk);
        cyc(1,0,'0,0,4'd0,0,8'd0,0,0);
        check("reset_count", count, 16'h0100);
        check("reset_prev",  prev,  16'h0100);
        check("reset_wrap",  W'(wrap), '0);
        do_inc(); do_inc(); do_inc();
        check("inc3_count", count, 16'h0103);
        check("inc3_prev",  prev,  16'h0102);

        do_ld(16'h0150);
        check("ld_count", count, 16'h0150);
        do_rel(8'hFE);
        check("rel_neg", count, 16'h014E);
        do_rel(8'h7F);
        check("rel_pos", count, 16'h01CD);
        do_rel(8'h00);
        check("rel_zero_count", count, 16'h01CD);
        check("rel_zero_prev",  prev,  16'h01CD);
        do_rel(8'h80);
        check("rel_min", count, 16'h014D);

        do_vec(4'd7);
        check("vec7", count, 16'h0038);
        do_vec(4'd10);
        check("vec10", count, 16'h0050);
        check("vec10_prev", prev, 16'h0038);
        do_vec(4'd12);
        check("vec12", count, 16'h0060);
        do_vec(4'd14);
        check("vec14_count", count, 16'h0060);
        check("vec14_prev",  prev,  16'h0050);
        check("vec14_verr",  W'(verr), 16'h0001);
        do_idle();
        check("verr_pulse_end", W'(verr), '0);
        cyc(0,0,'0,1,4'd15,1,8'h10,1,0);
        check("vec15_no_fallthru", count, 16'h0060);

        do_ld(16'hFFFF);
        do_inc();
        check("wrap_count", count, 16'h0000);
        check("wrap_hi", W'(wrap), 16'h0001);
        do_idle();
        check("wrap_pulse_end", W'(wrap), '0);
        do_ld(16'hFFFF);
        do_rel(8'h01);
        check("rel_wrap_count", count, 16'h0000);
        check("rel_no_wrap", W'(wrap), '0);
        cyc(0,1,16'h1234,0,4'd0,0,8'd0,1,0);
        check("ld_over_inc", count, 16'h1234);

        do_ld(16'h0200);
        cyc(0,0,'0,0,4'd0,0,8'd0,0,1);
        do_inc();
`ifdef PC_HALT_BUG_EN
        check("hbug_first", count, 16'h0200);
`else
        check("hbug_ignored", count, 16'h0201);
`endif
        do_inc();
`ifdef PC_HALT_BUG_EN
        check("hbug_second", count, 16'h0201);
`else
        check("hbug_ignored2", count, 16'h0202);
`endif

        do_ld(16'hFFFF);
        cyc(1,1,16'h5555,1,4'd14,0,8'd0,1,1);
        check("rst_ovr_count", count, 16'h0100);
        check("rst_ovr_prev",  prev,  16'h0100);
        check("rst_ovr_wrap",  W'(wrap), '0);
        check("rst_ovr_verr",  W'(verr), '0);
        do_inc();
        check("rst_clears_flag", count, 16'h0101);
        do_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, limit %0d ns", 100000);
        $fatal(1);
    end

endmodule
